// File: rtl/pipeline_hazard_unit_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pipeline_hazard_unit_pkg: hazard FSM encodings and decode helpers |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package pipeline_hazard_unit_pkg;

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    STALL2 = 1'b1
  } hazard_state_t;

  localparam int c_REG_W = 5;

  localparam logic [5:0] c_OP_RTYPE = 6'h00;
  localparam logic [5:0] c_OP_J     = 6'h02;
  localparam logic [5:0] c_OP_JAL   = 6'h03;
  localparam logic [5:0] c_OP_BEQ   = 6'h04;
  localparam logic [5:0] c_OP_BNE   = 6'h05;
  localparam logic [5:0] c_OP_SB    = 6'h28;
  localparam logic [5:0] c_OP_SH    = 6'h29;
  localparam logic [5:0] c_OP_SW    = 6'h2B;
  localparam logic [5:0] c_FUNCT_JR = 6'h08;

  // JR is an R-type but only reads Rs, so it must not flag an Rt dependency.
  function automatic logic op_uses_rt(input logic [5:0] op, input logic [5:0] funct);
    logic r;
    r = 1'b0;
    case (op)
      c_OP_RTYPE:                       r = (funct != c_FUNCT_JR);
      c_OP_BEQ, c_OP_BNE:               r = 1'b1;
      c_OP_SB, c_OP_SH, c_OP_SW:        r = 1'b1;
      default:                          r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic op_jump_reg(input logic [5:0] op, input logic [5:0] funct);
    return (op == c_OP_RTYPE) && (funct == c_FUNCT_JR);
  endfunction

  function automatic logic op_is_jump(input logic [5:0] op, input logic [5:0] funct);
    return (op == c_OP_J) || (op == c_OP_JAL) || op_jump_reg(op, funct);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipeline_hazard_unit_sat_counter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | hazard_sat_counter: saturating event counter, async active-low   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module hazard_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Inc,
  output logic [CNT_W-1:0] Count
);

  localparam logic [CNT_W-1:0] c_MAX = '1;
  localparam logic [CNT_W-1:0] c_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_count <= '0;
    end else if (Inc && (r_count != c_MAX)) begin
      r_count <= r_count + c_ONE;
    end
  end

  assign Count = r_count;

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pipeline_hazard_unit: load-use / branch-operand stall and flush   |
// | control for a 5-stage MIPS pipeline with ID-resolved branches     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module pipeline_hazard_unit
  import pipeline_hazard_unit_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int REG_W = c_REG_W
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [REG_W-1:0] ID_Rs,
  input  logic [REG_W-1:0] ID_Rt,
  input  logic             ID_UsesRt,
  input  logic             ID_Branch,
  input  logic             ID_Jump,
  input  logic             ID_JumpReg,
  input  logic             ID_BranchTaken,
  input  logic             IDEX_RegWrite,
  input  logic             IDEX_MemRead,
  input  logic [REG_W-1:0] IDEX_WriteReg,
  input  logic             EXMEM_MemRead,
  input  logic [REG_W-1:0] EXMEM_WriteReg,
  output logic             PCWrite,
  output logic             IFID_Write,
  output logic             IFID_Flush,
  output logic             IDEX_Bubble,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  hazard_state_t r_state;

  function automatic logic reg_match(input logic [REG_W-1:0] a, input logic [REG_W-1:0] b);
    return (a == b) && (a != '0);
  endfunction

  logic w_ex_hit;
  logic w_mem_hit;
  logic w_id_cmp;
  logic w_lu;
  logic w_ba;
  logic w_bl2;
  logic w_bl1;
  logic w_stall;

  assign w_ex_hit  = reg_match(IDEX_WriteReg, ID_Rs) |
                     (ID_UsesRt & reg_match(IDEX_WriteReg, ID_Rt));
  assign w_mem_hit = reg_match(EXMEM_WriteReg, ID_Rs) |
                     (ID_UsesRt & reg_match(EXMEM_WriteReg, ID_Rt));

  // Branches and JR read their operands in ID, so they need results earlier than ALU ops.
  assign w_id_cmp = ID_Branch | ID_JumpReg;
  assign w_lu     = IDEX_MemRead & w_ex_hit;
  assign w_ba     = w_id_cmp & IDEX_RegWrite & ~IDEX_MemRead & w_ex_hit;
  assign w_bl2    = w_id_cmp & IDEX_MemRead & w_ex_hit;
  assign w_bl1    = w_id_cmp & EXMEM_MemRead & w_mem_hit;

  assign w_stall  = (r_state == STALL2) | w_lu | w_ba | w_bl2 | w_bl1;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state <= RUN;
    end else begin
      case (r_state)
        RUN:     r_state <= w_bl2 ? STALL2 : RUN;
        STALL2:  r_state <= RUN;
        default: r_state <= RUN;
      endcase
    end
  end

  always_comb begin
    PCWrite     = 1'b0;
    IFID_Write  = 1'b0;
    IFID_Flush  = 1'b0;
    IDEX_Bubble = 1'b1;
    if (Reset && !w_stall) begin
      PCWrite     = 1'b1;
      IFID_Write  = 1'b1;
      IDEX_Bubble = 1'b0;
      IFID_Flush  = ID_Jump | (ID_Branch & ID_BranchTaken);
    end
  end

  hazard_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .Clock (Clock),
    .Reset (Reset),
    .Inc   (w_stall),
    .Count (StallCount)
  );

  hazard_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .Clock (Clock),
    .Reset (Reset),
    .Inc   (IFID_Flush),
    .Count (FlushCount)
  );

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_pipeline_hazard_unit: directed vectors for the hazard unit     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_pipeline_hazard_unit;

  logic       r_clk;
  logic       r_rst_n;
  logic [4:0] r_id_rs, r_id_rt, r_idex_wr, r_exmem_wr;
  logic       r_uses_rt, r_branch, r_jump, r_jreg, r_taken;
  logic       r_idex_rw, r_idex_mr, r_exmem_mr;

  logic        w_pcw, w_ifidw, w_flush, w_bubble;
  logic [15:0] w_scnt, w_fcnt;
  logic        w_pcw_s, w_ifidw_s, w_flush_s, w_bubble_s;
  logic [1:0]  w_scnt_s, w_fcnt_s;

  int n_vec = 0;
  int n_bad = 0;

  pipeline_hazard_unit #(.CNT_W(16), .REG_W(5)) dut (
    .Clock(r_clk), .Reset(r_rst_n),
    .ID_Rs(r_id_rs), .ID_Rt(r_id_rt), .ID_UsesRt(r_uses_rt),
    .ID_Branch(r_branch), .ID_Jump(r_jump), .ID_JumpReg(r_jreg), .ID_BranchTaken(r_taken),
    .IDEX_RegWrite(r_idex_rw), .IDEX_MemRead(r_idex_mr), .IDEX_WriteReg(r_idex_wr),
    .EXMEM_MemRead(r_exmem_mr), .EXMEM_WriteReg(r_exmem_wr),
    .PCWrite(w_pcw), .IFID_Write(w_ifidw), .IFID_Flush(w_flush), .IDEX_Bubble(w_bubble),
    .StallCount(w_scnt), .FlushCount(w_fcnt)
  );

  pipeline_hazard_unit #(.CNT_W(2), .REG_W(5)) dut_small (
    .Clock(r_clk), .Reset(r_rst_n),
    .ID_Rs(r_id_rs), .ID_Rt(r_id_rt), .ID_UsesRt(r_uses_rt),
    .ID_Branch(r_branch), .ID_Jump(r_jump), .ID_JumpReg(r_jreg), .ID_BranchTaken(r_taken),
    .IDEX_RegWrite(r_idex_rw), .IDEX_MemRead(r_idex_mr), .IDEX_WriteReg(r_idex_wr),
    .EXMEM_MemRead(r_exmem_mr), .EXMEM_WriteReg(r_exmem_wr),
    .PCWrite(w_pcw_s), .IFID_Write(w_ifidw_s), .IFID_Flush(w_flush_s), .IDEX_Bubble(w_bubble_s),
    .StallCount(w_scnt_s), .FlushCount(w_fcnt_s)
  );

  initial r_clk = 1'b0;
  always #5 r_clk = ~r_clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled mid-cycle.
  task automatic tick();
    @(posedge r_clk);
    #1;
  endtask

  task automatic clear_inputs();
    r_id_rs = 5'd0; r_id_rt = 5'd0; r_idex_wr = 5'd0; r_exmem_wr = 5'd0;
    r_uses_rt = 1'b0; r_branch = 1'b0; r_jump = 1'b0; r_jreg = 1'b0; r_taken = 1'b0;
    r_idex_rw = 1'b0; r_idex_mr = 1'b0; r_exmem_mr = 1'b0;
  endtask

  initial begin
    clear_inputs();
    r_rst_n = 1'b0;

    // Reset held for three cycles
    tick(); tick(); tick();
    check_eq("rst_pcwrite", w_pcw, 0);
    check_eq("rst_ifidw",   w_ifidw, 0);
    check_eq("rst_bubble",  w_bubble, 1);
    check_eq("rst_flush",   w_flush, 0);
    check_eq("rst_scnt",    w_scnt, 0);
    check_eq("rst_fcnt",    w_fcnt, 0);
    r_rst_n = 1'b1;
    #1;
    check_eq("rel_pcwrite", w_pcw, 1);
    check_eq("rel_bubble",  w_bubble, 0);

    // LW $8 in EX, ADD reading $8 in ID: one stall
    r_idex_mr = 1'b1; r_idex_rw = 1'b1; r_idex_wr = 5'd8;
    r_id_rs = 5'd8; r_id_rt = 5'd3; r_uses_rt = 1'b1;
    #1;
    check_eq("lu_pcwrite", w_pcw, 0);
    check_eq("lu_ifidw",   w_ifidw, 0);
    check_eq("lu_bubble",  w_bubble, 1);
    tick();
    check_eq("lu_scnt", w_scnt, 1);
    r_idex_mr = 1'b0; r_idex_rw = 1'b0; r_idex_wr = 5'd0;
    r_exmem_mr = 1'b1; r_exmem_wr = 5'd8;
    #1;
    check_eq("lu_resume", w_pcw, 1);
    tick();
    check_eq("lu_scnt_hold", w_scnt, 1);

    // LW $9 in EX, BEQ on $9: two stalls; second owed by STALL2 alone
    clear_inputs();
    r_idex_mr = 1'b1; r_idex_rw = 1'b1; r_idex_wr = 5'd9;
    r_branch = 1'b1; r_id_rs = 5'd9; r_id_rt = 5'd2; r_uses_rt = 1'b1;
    #1;
    check_eq("bl2_stall1", w_pcw, 0);
    tick();
    r_idex_mr = 1'b0; r_idex_rw = 1'b0; r_idex_wr = 5'd0;
    #1;
    check_eq("bl2_stall2",  w_pcw, 0);
    check_eq("bl2_noflush", w_flush, 0);
    check_eq("bl2_scnt1",   w_scnt, 2);
    tick();
    check_eq("bl2_scnt2", w_scnt, 3);
    check_eq("bl2_run",   w_pcw, 1);
    check_eq("bl2_fcnt",  w_fcnt, 0);

    // Load in MEM feeding BEQ: single stall then back to RUN
    clear_inputs();
    r_exmem_mr = 1'b1; r_exmem_wr = 5'd4;
    r_branch = 1'b1; r_id_rs = 5'd1; r_id_rt = 5'd4; r_uses_rt = 1'b1;
    #1;
    check_eq("bl1_stall", w_pcw, 0);
    tick();
    r_exmem_mr = 1'b0;
    #1;
    check_eq("bl1_run",  w_pcw, 1);
    check_eq("bl1_scnt", w_scnt, 4);

    // ADD $5 in EX, taken BNE on Rt=5: stall, then flush
    clear_inputs();
    r_idex_rw = 1'b1; r_idex_wr = 5'd5;
    r_branch = 1'b1; r_taken = 1'b1; r_id_rs = 5'd1; r_id_rt = 5'd5; r_uses_rt = 1'b1;
    #1;
    check_eq("ba_stall",   w_pcw, 0);
    check_eq("ba_noflush", w_flush, 0);
    tick();
    r_idex_rw = 1'b0; r_idex_wr = 5'd0;
    #1;
    check_eq("ba_flush", w_flush, 1);
    check_eq("ba_pcw",   w_pcw, 1);
    tick();
    check_eq("ba_fcnt", w_fcnt, 1);
    check_eq("ba_scnt", w_scnt, 5);

    // LW $0 never creates a dependency; then J flushes
    clear_inputs();
    r_idex_mr = 1'b1; r_idex_rw = 1'b1; r_idex_wr = 5'd0; r_id_rs = 5'd0;
    #1;
    check_eq("r0_nostall", w_pcw, 1);
    r_idex_wr = 5'd7; r_id_rs = 5'd1; r_id_rt = 5'd7; r_uses_rt = 1'b0;
    #1;
    check_eq("rt_unused_nostall", w_pcw, 1);
    clear_inputs();
    r_jump = 1'b1;
    #1;
    check_eq("j_flush", w_flush, 1);
    check_eq("j_pcw",   w_pcw, 1);
    tick();
    check_eq("j_fcnt", w_fcnt, 2);
    clear_inputs();

    // Five more stalls: wide counter advances, 2-bit counter pinned at 3
    r_idex_mr = 1'b1; r_idex_rw = 1'b1; r_idex_wr = 5'd12; r_id_rs = 5'd12;
    for (int i = 0; i < 5; i++) tick();
    check_eq("sat_scnt_wide",  w_scnt, 10);
    check_eq("sat_scnt_small", w_scnt_s, 3);
    check_eq("sat_fcnt_small", w_fcnt_s, 2);

    // Reset during STALL2 drops the owed stall
    clear_inputs();
    r_idex_mr = 1'b1; r_idex_rw = 1'b1; r_idex_wr = 5'd9; r_branch = 1'b1; r_id_rs = 5'd9;
    tick();
    clear_inputs();
    #1;
    check_eq("s2_entered", w_pcw, 0);
    r_rst_n = 1'b0;
    #1;
    check_eq("s2_rst_bubble", w_bubble, 1);
    check_eq("s2_rst_scnt",   w_scnt, 0);
    tick();
    r_rst_n = 1'b1;
    #1;
    check_eq("s2_rst_run", w_pcw, 1);
    tick();
    check_eq("s2_rst_scnt_after", w_scnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
